// File: rtl/codec_pkg.sv
// Shared codec parameters and the chunk-index to encoder-select mapping.
package codec_pkg;

  localparam int K_DEF    = 1024;
  localparam int LM_DEF   = 16;
  localparam int LA_DEF   = 8;
  localparam int M_DEF    = 32;
  localparam int DIV_DEF  = K_DEF / (M_DEF * LA_DEF);
  localparam int IDX_BITS = $clog2(DIV_DEF);

  // Chunk index 0 fills the low slice, which the encoder selects last (sel=3).
  function automatic logic [IDX_BITS-1:0] idx_to_sel(input logic [IDX_BITS-1:0] idx);
    return 2'd3 - idx;
  endfunction

endpackage

// File: rtl/msg_assembler.sv
// Rebuilds a K-bit message from four sequential M*La-bit chunks.
// State is the chunk index plus the output-hold flag; no separate state register.
module msg_assembler
  import codec_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int M  = M_DEF,
  parameter int La = LA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M*La-1:0]   chunk_in,
  input  logic              chunk_first,
  input  logic              chunk_valid,
  output logic              chunk_ready,
  output logic [1:0]        sel,
  output logic [K-1:0]      msg_out,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic              frame_err
);

  localparam int CW    = M * La;
  localparam int BUF_W = 3 * CW;

  logic [IDX_BITS-1:0] idx_r;
  logic [IDX_BITS-1:0] idx_nxt_s;
  logic [BUF_W-1:0]    asm_buf_r;
  logic [BUF_W-1:0]    asm_buf_nxt_s;
  logic [K-1:0]        msg_out_r;
  logic [K-1:0]        msg_out_nxt_s;
  logic                msg_valid_r;
  logic                msg_valid_nxt_s;
  logic                frame_err_r;
  logic                frame_err_nxt_s;
  logic                accept_s;
  logic                load_s;
  logic                wr_en_s;
  logic [IDX_BITS-1:0] wr_idx_s;

  // The 4th chunk stalls only while a finished message is still waiting for the sink.
  assign chunk_ready = !((idx_r == 2'd3) && msg_valid_r && !msg_ready);
  assign sel         = idx_to_sel(idx_r);
  assign msg_out     = msg_out_r;
  assign msg_valid   = msg_valid_r;
  assign frame_err   = frame_err_r;

  // Classify each accepted chunk: resync, drop, slice write or frame completion.
  always_comb begin
    accept_s        = chunk_valid && chunk_ready;
    load_s          = 1'b0;
    wr_en_s         = 1'b0;
    wr_idx_s        = idx_r;
    idx_nxt_s       = idx_r;
    frame_err_nxt_s = 1'b0;
    if (accept_s) begin
      if (chunk_first && (idx_r != 2'd0)) begin
        // Abandon the partial frame; stale upper slices are rewritten before the next load.
        wr_en_s         = 1'b1;
        wr_idx_s        = 2'd0;
        idx_nxt_s       = 2'd1;
        frame_err_nxt_s = 1'b1;
      end else if (!chunk_first && (idx_r == 2'd0)) begin
        frame_err_nxt_s = 1'b1;
      end else if (idx_r == 2'd3) begin
        load_s    = 1'b1;
        idx_nxt_s = 2'd0;
      end else begin
        wr_en_s   = 1'b1;
        idx_nxt_s = idx_r + 2'd1;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Decoded slice enable into the three-chunk assembly buffer.
  always_comb begin
    asm_buf_nxt_s = asm_buf_r;
    if (wr_en_s) begin
      case (wr_idx_s)
        2'd0:    asm_buf_nxt_s[CW-1:0]      = chunk_in;
        2'd1:    asm_buf_nxt_s[2*CW-1:CW]   = chunk_in;
        2'd2:    asm_buf_nxt_s[3*CW-1:2*CW] = chunk_in;
        default: asm_buf_nxt_s              = asm_buf_r;
      endcase
    end else begin
      asm_buf_nxt_s = asm_buf_r;
    end
  end

  // Output hold: a load wins over a completing handshake so frames can run back to back.
  always_comb begin
    msg_out_nxt_s   = msg_out_r;
    msg_valid_nxt_s = msg_valid_r;
    if (load_s) begin
      msg_out_nxt_s   = {chunk_in, asm_buf_r};
      msg_valid_nxt_s = 1'b1;
    end else if (msg_valid_r && msg_ready) begin
      msg_valid_nxt_s = 1'b0;
    end else begin
      msg_valid_nxt_s = msg_valid_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= 2'd0;
      asm_buf_r   <= '0;
      msg_out_r   <= '0;
      msg_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      asm_buf_r   <= asm_buf_nxt_s;
      msg_out_r   <= msg_out_nxt_s;
      msg_valid_r <= msg_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

endmodule
